// File: rtl/mul_accum.sv
// mul_accum: sums SIZE 64-bit partial products LANES per cycle, sign-corrects the total and
// returns the selected 32-bit half. Define MUL_ACCUM_DROP_CNT_EN to enable the dropped-start counter.
module mul_accum #(
    parameter int SIZE  = 16,
    parameter int LANES = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_i,
    input  logic [64*SIZE-1:0]  partial_i,
    input  logic [1:0]          sign_i,
    input  logic                higher_i,
    output logic                ready_o,
    output logic                valid_o,
    output logic [31:0]         result_o,
    output logic [7:0]          drop_cnt_o
);
    localparam int GROUPS = SIZE / LANES;
    localparam int GW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    localparam logic [GW-1:0] GRP_LAST = GW'(GROUPS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t               state_r;
    logic                 ready_r;
    logic                 valid_r;
    logic [31:0]          result_r;
    logic [63:0]          acc_r;
    logic [GW-1:0]        grp_r;
    logic [64*SIZE-1:0]   buf_r;
    logic [1:0]           sign_r;
    logic                 higher_r;
    logic [63:0]          grp_sum_s;
    logic [63:0]          prod_s;

    // Sum of the LANES buffered partials selected by the current group index.
    always_comb begin
        grp_sum_s = 64'd0;
        for (int l = 0; l < LANES; l++) begin
            grp_sum_s = grp_sum_s + buf_r[64*(LANES*int'(grp_r) + l) +: 64];
        end
    end

    // Two's-complement the magnitude when exactly one operand was negative.
    always_comb begin
        if (sign_r[1] ^ sign_r[0]) begin
            prod_s = ~acc_r + 64'd1;
        end else begin
            prod_s = acc_r;
        end
    end

    // Operation FSM: capture on start, accumulate GROUPS cycles, finish with a valid pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= IDLE;
            ready_r  <= 1'b1;
            valid_r  <= 1'b0;
            result_r <= 32'd0;
            acc_r    <= 64'd0;
            grp_r    <= {GW{1'b0}};
            buf_r    <= {(64*SIZE){1'b0}};
            sign_r   <= 2'b00;
            higher_r <= 1'b0;
        end else begin
            valid_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start_i) begin
                        buf_r    <= partial_i;
                        sign_r   <= sign_i;
                        higher_r <= higher_i;
                        acc_r    <= 64'd0;
                        grp_r    <= {GW{1'b0}};
                        ready_r  <= 1'b0;
                        state_r  <= ACC;
                    end
                end
                ACC: begin
                    acc_r <= acc_r + grp_sum_s;
                    if (grp_r == GRP_LAST) begin
                        grp_r   <= {GW{1'b0}};
                        state_r <= FIN;
                    end else begin
                        grp_r <= grp_r + 1'b1;
                    end
                end
                FIN: begin
                    result_r <= higher_r ? prod_s[63:32] : prod_s[31:0];
                    valid_r  <= 1'b1;
                    ready_r  <= 1'b1;
                    state_r  <= IDLE;
                end
                default: begin
                    ready_r <= 1'b1;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign ready_o  = ready_r;
    assign valid_o  = valid_r;
    assign result_o = result_r;

`ifdef MUL_ACCUM_DROP_CNT_EN
    logic [7:0] drop_cnt_r;

    // Saturating count of start pulses that arrive while busy.
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt_r <= 8'd0;
        end else if (start_i && !ready_r && (drop_cnt_r != 8'hFF)) begin
            drop_cnt_r <= drop_cnt_r + 8'd1;
        end else begin
            drop_cnt_r <= drop_cnt_r;
        end
    end

    assign drop_cnt_o = drop_cnt_r;
`else
    assign drop_cnt_o = 8'd0;
`endif

endmodule

// File: tb/tb_mul_accum.sv
// Scoreboard bench for mul_accum: the driver pushes expected results with their arrival edge,
// a negedge monitor pops and compares whenever valid_o is high.
module tb_mul_accum;
    localparam int SIZE = 16;

    logic                clk = 1'b0;
    logic                rst;
    logic                start_i;
    logic [64*SIZE-1:0]  partial_i;
    logic [1:0]          sign_i;
    logic                higher_i;
    logic                ready_o;
    logic                valid_o;
    logic [31:0]         result_o;
    logic [7:0]          drop_cnt_o;

    typedef struct {
        logic [31:0] res;
        int          cyc;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   chk_cnt = 0;
    int   pass_cnt = 0;
    int   exp_drop;

    mul_accum #(.SIZE(SIZE), .LANES(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_i),
        .partial_i  (partial_i),
        .sign_i     (sign_i),
        .higher_i   (higher_i),
        .ready_o    (ready_o),
        .valid_o    (valid_o),
        .result_o   (result_o),
        .drop_cnt_o (drop_cnt_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [64*SIZE-1:0] mk(input logic [63:0] v0, input logic [63:0] v1,
                                              input logic [63:0] rest);
        logic [64*SIZE-1:0] p;
        for (int k = 0; k < SIZE; k++) p[64*k +: 64] = rest;
        p[63:0]   = v0;
        p[127:64] = v1;
        return p;
    endfunction

    // Monitor: every valid_o must match the oldest expected entry, on the predicted edge.
    always @(negedge clk) begin
        if (rst === 1'b0 && valid_o === 1'b1) begin
            if (q.size() == 0) begin
                chk("unexpected_valid", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("result", {32'd0, result_o}, {32'd0, e.res});
                chk("latency_edge", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    // Drive one start pulse; returns #1 after the edge that sampled it.
    task automatic issue(input logic [64*SIZE-1:0] p, input logic [1:0] s, input logic h,
                         input logic [31:0] exp, input bit push);
        exp_t e;
        chk("ready_before_start", {63'd0, ready_o}, 64'd1);
        partial_i = p;
        sign_i    = s;
        higher_i  = h;
        start_i   = 1'b1;
        if (push) begin
            e.res = exp;
            e.cyc = cyc + 6;
            q.push_back(e);
        end
        @(posedge clk);
        #1;
        start_i   = 1'b0;
        partial_i = {SIZE{64'hDEAD_BEEF_0BAD_F00D}};
        sign_i    = ~s;
        higher_i  = ~h;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
        if (q.size() != 0) begin
            chk("timeout_waiting_valid", 64'(q.size()), 64'd0);
            q.delete();
        end
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        start_i   = 1'b0;
        partial_i = '0;
        sign_i    = 2'b00;
        higher_i  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ready", {63'd0, ready_o}, 64'd1);
        chk("reset_valid", {63'd0, valid_o}, 64'd0);
        chk("reset_result", {32'd0, result_o}, 64'd0);
        chk("reset_drop", {56'd0, drop_cnt_o}, 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // All ones: busy for exactly 5 cycles.
        issue(mk(64'h1, 64'h1, 64'h1), 2'b00, 1'b0, 32'h10, 1'b1);
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            chk("ready_low_busy", {63'd0, ready_o}, 64'd0);
        end
        @(negedge clk);
        chk("ready_back_high", {63'd0, ready_o}, 64'd1);
        wait_done();

        issue(mk(64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'h0), 2'b00, 1'b1, 32'h1, 1'b1);
        wait_done();
        issue(mk(64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'h0), 2'b00, 1'b0, 32'hFFFF_FFFE, 1'b1);
        wait_done();
        issue(mk(64'h5, 64'h0, 64'h0), 2'b10, 1'b0, 32'hFFFF_FFFB, 1'b1);
        wait_done();
        issue(mk(64'h5, 64'h0, 64'h0), 2'b10, 1'b1, 32'hFFFF_FFFF, 1'b1);
        wait_done();
        issue(mk(64'h5, 64'h0, 64'h0), 2'b11, 1'b0, 32'h5, 1'b1);
        wait_done();
        issue(mk(64'h5, 64'h0, 64'h0), 2'b01, 1'b0, 32'hFFFF_FFFB, 1'b1);
        wait_done();
        issue({SIZE{64'hFFFF_FFFF_FFFF_FFFF}}, 2'b00, 1'b0, 32'hFFFF_FFF0, 1'b1);
        wait_done();
        issue({SIZE{64'hFFFF_FFFF_FFFF_FFFF}}, 2'b00, 1'b1, 32'hFFFF_FFFF, 1'b1);
        wait_done();

        // Start pulse while busy is ignored (and counted when the counter is built in).
        issue(mk(64'h7, 64'h3, 64'h0), 2'b00, 1'b0, 32'hA, 1'b1);
        @(posedge clk);
        #1;
        partial_i = mk(64'h100, 64'h100, 64'h100);
        start_i   = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        wait_done();
`ifdef MUL_ACCUM_DROP_CNT_EN
        exp_drop = 1;
`else
        exp_drop = 0;
`endif
        chk("drop_cnt", {56'd0, drop_cnt_o}, 64'(exp_drop));

        // Back-to-back: second start in the valid_o cycle.
        issue(mk(64'h2, 64'h2, 64'h2), 2'b00, 1'b0, 32'h20, 1'b1);
        repeat (5) @(posedge clk);
        #1;
        chk("b2b_valid_now", {63'd0, valid_o}, 64'd1);
        issue(mk(64'h9, 64'h0, 64'h0), 2'b11, 1'b0, 32'h9, 1'b1);
        wait_done();

        // Reset during the second ACC cycle aborts the operation silently.
        issue(mk(64'h1, 64'h1, 64'h1), 2'b00, 1'b0, 32'h10, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("abort_ready", {63'd0, ready_o}, 64'd1);
        chk("abort_valid", {63'd0, valid_o}, 64'd0);
        chk("abort_result", {32'd0, result_o}, 64'd0);
        chk("abort_drop", {56'd0, drop_cnt_o}, 64'd0);
        repeat (8) @(posedge clk);
        #1;
        issue(mk(64'h1, 64'h1, 64'h1), 2'b00, 1'b0, 32'h10, 1'b1);
        wait_done();

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
